// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter onto a single-port data memory with 1-cycle read latency.
// Define DMEM_ARB_RR_EN for round-robin on contention; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [WIDTH-1:0]  p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [WIDTH-1:0]  p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [WIDTH-1:0]  p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [WIDTH-1:0]  p1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata
);
  logic last_gnt, rd_pend, rd_port, pick1;
`ifdef DMEM_ARB_RR_EN
  assign pick1 = ~last_gnt;
`else
  assign pick1 = 1'b0;
`endif
  // rst gates outputs combinationally so nothing leaks while reset is held
  always_comb begin
    p1_gnt    = ~rst & p1_req & (~p0_req | pick1);
    p0_gnt    = ~rst & p0_req & ~p1_gnt;
    mem_we    = p1_gnt ? p1_we : (p0_gnt & p0_we);
    mem_addr  = p1_gnt ? p1_addr : p0_addr;
    mem_wdata = p1_gnt ? p1_wdata : p0_wdata;
    p0_rvalid = ~rst & rd_pend & ~rd_port;
    p1_rvalid = ~rst & rd_pend & rd_port;
    p0_rdata  = p0_rvalid ? mem_rdata : '0;
    p1_rdata  = p1_rvalid ? mem_rdata : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
      rd_pend  <= 1'b0;
      rd_port  <= 1'b0;
    end else begin
      rd_pend <= (p0_gnt | p1_gnt) & ~mem_we;
      if (p0_gnt | p1_gnt) begin
        last_gnt <= p1_gnt;
        rd_port  <= p1_gnt;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter (both arbitration modes).
module tb_dmem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [15:0] p0_addr = 0, p1_addr = 0, mem_addr;
  logic [31:0] p0_wdata = 0, p1_wdata = 0, mem_wdata, mem_rdata = 0;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we;
  int          checks = 0, errors = 0;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // reset held with both ports requesting
    p0_req = 1; p1_req = 1; p0_we = 1; mem_rdata = 32'hFFFF_FFFF;
    cyc(); #1;
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p1_gnt", p1_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_p0_rvalid", p0_rvalid, 0);
    chk("rst_p1_rvalid", p1_rvalid, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_p1_rdata", p1_rdata, 0);
    // contention right after reset: both reading for 4 cycles
    p0_we = 0; rst = 0;
    #1;
    chk("cont0_p0_gnt", p0_gnt, 1);
    chk("cont0_p1_gnt", p1_gnt, 0);
    cyc(); #1;
    chk("cont1_p0_gnt", p0_gnt, RR ? 0 : 1);
    chk("cont1_p1_gnt", p1_gnt, RR ? 1 : 0);
    cyc(); #1;
    chk("cont2_p0_gnt", p0_gnt, 1);
    chk("cont2_p1_gnt", p1_gnt, 0);
    cyc(); #1;
    chk("cont3_p0_gnt", p0_gnt, RR ? 0 : 1);
    chk("cont3_p1_gnt", p1_gnt, RR ? 1 : 0);
    cyc(); p0_req = 0; p1_req = 0; mem_rdata = 32'h0BAD_F00D; #1;
    chk("cont_tail_p0_rvalid", p0_rvalid, RR ? 0 : 1);
    chk("cont_tail_p1_rvalid", p1_rvalid, RR ? 1 : 0);
    chk("cont_tail_p1_rdata", p1_rdata, RR ? 32'h0BAD_F00D : 0);
    // single read from p0
    cyc(); p0_req = 1; p0_we = 0; p0_addr = 16'h0010; #1;
    chk("rd_p0_gnt", p0_gnt, 1);
    chk("rd_p1_gnt", p1_gnt, 0);
    chk("rd_mem_addr", mem_addr, 32'h0010);
    chk("rd_mem_we", mem_we, 0);
    cyc(); p0_req = 0; mem_rdata = 32'hDEAD_BEEF; #1;
    chk("rd_p0_rvalid", p0_rvalid, 1);
    chk("rd_p0_rdata", p0_rdata, 32'hDEAD_BEEF);
    chk("rd_p1_rvalid", p1_rvalid, 0);
    chk("rd_p1_rdata", p1_rdata, 0);
    cyc(); #1;
    chk("rd_after_p0_rvalid", p0_rvalid, 0);
    chk("rd_after_p0_rdata", p0_rdata, 0);
    // p1 write then p0 read of the same address
    cyc(); p1_req = 1; p1_we = 1; p1_addr = 16'h0004; p1_wdata = 32'h1234_5678;
    p0_addr = 16'h0020; p0_wdata = 32'h5555_AAAA; #1;
    chk("wr_p1_gnt", p1_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 32'h0004);
    chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    cyc(); p1_req = 0; p1_we = 0; p0_req = 1; p0_we = 0; p0_addr = 16'h0004; #1;
    chk("wr_rd_p0_gnt", p0_gnt, 1);
    chk("wr_rd_mem_we", mem_we, 0);
    chk("wr_rd_p0_rvalid", p0_rvalid, 0);
    chk("wr_rd_p1_rvalid", p1_rvalid, 0);
    cyc(); p0_req = 0; p0_we = 1; p0_addr = 16'h0030; p1_addr = 16'h0008;
    mem_rdata = 32'h1234_5678; #1;
    chk("wr_rd3_p0_rvalid", p0_rvalid, 1);
    chk("wr_rd3_p0_rdata", p0_rdata, 32'h1234_5678);
    chk("wr_rd3_p1_rvalid", p1_rvalid, 0);
    chk("idle_mem_we", mem_we, 0);
    chk("idle_mem_addr", mem_addr, 32'h0030);
    // back-to-back cross-port reads
    cyc(); p0_req = 1; p0_we = 0; p0_addr = 16'h0040; #1;
    chk("b2b_p0_gnt", p0_gnt, 1);
    cyc(); p0_req = 0; p1_req = 1; p1_we = 0; p1_addr = 16'h0044; mem_rdata = 32'h0000_00A1; #1;
    chk("b2b_p1_gnt", p1_gnt, 1);
    chk("b2b_mem_addr", mem_addr, 32'h0044);
    chk("b2b_p0_rvalid", p0_rvalid, 1);
    chk("b2b_p0_rdata", p0_rdata, 32'h0000_00A1);
    chk("b2b_p1_rvalid_early", p1_rvalid, 0);
    chk("b2b_p1_rdata_early", p1_rdata, 0);
    cyc(); p1_req = 0; mem_rdata = 32'h0000_00B2; #1;
    chk("b2b_p1_rvalid", p1_rvalid, 1);
    chk("b2b_p1_rdata", p1_rdata, 32'h0000_00B2);
    chk("b2b_p0_rvalid_late", p0_rvalid, 0);
    chk("b2b_p0_rdata_late", p0_rdata, 0);
    // reset in the cycle after a p0 read grant
    cyc(); p0_req = 1; p0_addr = 16'h0050; #1;
    chk("rstrd_p0_gnt", p0_gnt, 1);
    cyc(); p0_req = 0; rst = 1; mem_rdata = 32'h0000_00CC; #1;
    chk("rstrd_p0_rvalid_in", p0_rvalid, 0);
    chk("rstrd_p0_rdata_in", p0_rdata, 0);
    cyc(); rst = 0; #1;
    chk("rstrd_p0_rvalid_after", p0_rvalid, 0);
    cyc(); p0_req = 1; p1_req = 1; #1;
    chk("rstrd_cont_p0_gnt", p0_gnt, 1);
    chk("rstrd_cont_p1_gnt", p1_gnt, 0);
    cyc(); #1;
    chk("rstrd_cont2_p1_gnt", p1_gnt, RR ? 1 : 0);
    chk("rstrd_cont2_p0_gnt", p0_gnt, RR ? 0 : 1);
    cyc(); p0_req = 0; p1_req = 0;
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of both requester ports and of the memory port.
REQ-002 Parameter ADDR_W, default 16, byte-address width of both requester ports and of the memory port.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 p0_req  input  1  CPU load/store request.
REQ-006 p0_we  input  1  CPU write enable (1 = store, 0 = load).
REQ-007 p0_addr  input  ADDR_W  CPU address.
REQ-008 p0_wdata  input  WIDTH  CPU store data.
REQ-009 p0_gnt  output  1  CPU request accepted this cycle.
REQ-010 p0_rvalid  output  1  CPU load data valid.
REQ-011 p0_rdata  output  WIDTH  CPU load data.
REQ-012 p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same directions, widths and meanings as p0, for the debug/DMA requester.
REQ-013 mem_we  output  1  write strobe to single-port dmem.
REQ-014 mem_addr  output  ADDR_W  dmem address.
REQ-015 mem_wdata  output  WIDTH  dmem write data.
REQ-016 mem_rdata  input  WIDTH  dmem read data, valid one cycle after address presented.

Function
REQ-017 At most one of p0_gnt/p1_gnt SHALL be high in any cycle.
REQ-018 A grant SHALL be combinational from req and the arbitration state; px_gnt high only when px_req high.
REQ-019 A requester SHALL hold req, we, addr and wdata stable until it sees gnt; the transfer completes on the clock edge where req and gnt are both high.
REQ-020 mem_addr, mem_wdata and mem_we SHALL be muxed from the granted port; mem_we = granted port's we; with no grant, mem_we = 0 and mem_addr/mem_wdata = port 0 values.
REQ-021 A granted read SHALL produce px_rvalid = 1 for exactly one cycle, the cycle after the grant, with px_rdata = mem_rdata in that cycle.
REQ-022 A granted write SHALL produce no rvalid.
REQ-023 Back-to-back grants (one per cycle) SHALL be supported, including a read followed by a read from the other port; rvalid/rdata routing SHALL follow the registered port ID of the previous cycle's read.
REQ-024 px_rdata SHALL be 0 whenever px_rvalid = 0.
REQ-025 Arbitration state last_gnt (1 bit) SHALL update to the granted port ID on each grant and hold otherwise.
REQ-026 Only one requester active: that requester SHALL be granted the same cycle regardless of last_gnt.
REQ-027 Both requesting: winner SHALL be chosen per the Configuration section.
REQ-028 A single-bit rd_pend register and a 1-bit rd_port register SHALL track an outstanding read.

Reset
REQ-029 While rst is high: p0_gnt = p1_gnt = 0, mem_we = 0, p0_rvalid = p1_rvalid = 0, p0_rdata = p1_rdata = 0.
REQ-030 On rst assertion: last_gnt = 1 (so port 0 wins the first contended cycle), rd_pend = 0, rd_port = 0.
REQ-031 Reset asserted the cycle after a read grant SHALL discard that read; no rvalid SHALL appear after reset deasserts.

Configuration
REQ-032 Macro DMEM_ARB_RR_EN defined: contended cycles SHALL grant the port not equal to last_gnt (round-robin).
REQ-033 Macro DMEM_ARB_RR_EN undefined: contended cycles SHALL always grant port 0 (fixed priority); last_gnt still updates but does not affect arbitration.

Verification
REQ-034 Single read: p0 read addr 0x0010, mem_rdata = 0xDEADBEEF next cycle -> p0_gnt same cycle, p0_rvalid = 1 and p0_rdata = 0xDEADBEEF one cycle later, p1_rvalid = 0.
REQ-035 Contention, RR_EN defined: p0 and p1 hold read requests for 4 cycles after reset -> grants p0, p1, p0, p1.
REQ-036 Contention, RR_EN undefined: same stimulus -> p0 granted all 4 cycles, p1_gnt = 0.
REQ-037 Write then read: p1 write 0x0004 = 0x12345678, then p0 read 0x0004 next cycle -> mem_we = 1 only in the first cycle, p0_rvalid in the third cycle, p1_rvalid never.
REQ-038 Back-to-back cross-port reads: p0 read in cycle N, p1 read in cycle N+1 -> p0_rvalid in cycle N+1, p1_rvalid in cycle N+2, rdata routed to the correct port each cycle.
REQ-039 Reset mid-read: rst asserted in the cycle after a p0 read grant -> p0_rvalid stays 0 during and after reset; first contended grant after reset goes to p0.
